// File: rtl/exec_if.sv
// Execute-stage bus: upstream instruction handshake, operands and the downstream result beat.
// master drives instructions and accepts results; slave is the execute stage.
interface exec_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] r1_data;
    logic [XLEN-1:0] r2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [3:0]      alucode;
    logic            using_r2;
    logic            using_pc;
    logic [2:0]      info_branch;
    logic [3:0]      muldiv_op;
    logic [10:0]     meta_in;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [10:0]     meta_out;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output flush, in_valid, r1_data, r2_data, imm, pc, alucode, using_r2, using_pc,
               info_branch, muldiv_op, meta_in, out_ready,
        input  in_ready, out_valid, result, store_data, meta_out, redirect, redirect_pc
    );

    modport slave (
        input  flush, in_valid, r1_data, r2_data, imm, pc, alucode, using_r2, using_pc,
               info_branch, muldiv_op, meta_in, out_ready,
        output in_ready, out_valid, result, store_data, meta_out, redirect, redirect_pc
    );
endinterface

// File: rtl/exec_stage.sv
// Execute stage: one-cycle ALU/branch unit; iterative multiply/divide when EXEC_MULDIV_EN is defined.
// ALU codes: 0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA 8 OR 9 AND, others pass B.
module exec_stage #(
    parameter int XLEN = 32
) (
    input  logic  clk,
    input  logic  rst,
    exec_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] op_a, op_b, sum_ab, alu_res, md_res;
    logic [SHW-1:0]  shamt;
    logic            taken, accept, busy, md_start, md_fin;

    assign op_a   = bus.using_pc ? bus.pc : bus.r1_data;
    assign op_b   = bus.using_r2 ? bus.r2_data : bus.imm;
    assign sum_ab = op_a + op_b;
    assign shamt  = op_b[SHW-1:0];

    always_comb begin
        alu_res = op_b;
        case (bus.alucode)
            4'd0:    alu_res = sum_ab;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a << shamt;
            4'd3:    alu_res = XLEN'($signed(op_a) < $signed(op_b));
            4'd4:    alu_res = XLEN'(op_a < op_b);
            4'd5:    alu_res = op_a ^ op_b;
            4'd6:    alu_res = op_a >> shamt;
            4'd7:    alu_res = XLEN'($signed(op_a) >>> shamt);
            4'd8:    alu_res = op_a | op_b;
            4'd9:    alu_res = op_a & op_b;
            default: alu_res = op_b;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (bus.info_branch)
            3'd1:    taken = bus.r1_data == bus.r2_data;
            3'd2:    taken = bus.r1_data != bus.r2_data;
            3'd3:    taken = $signed(bus.r1_data) <  $signed(bus.r2_data);
            3'd4:    taken = $signed(bus.r1_data) >= $signed(bus.r2_data);
            3'd5:    taken = bus.r1_data <  bus.r2_data;
            3'd6:    taken = bus.r1_data >= bus.r2_data;
            3'd7:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    assign bus.in_ready = !rst && !busy && !bus.flush && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // redirect rides only on its own beat; a mul/div never redirects
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid   <= 1'b0;
            bus.redirect    <= 1'b0;
            bus.redirect_pc <= '0;
            bus.result      <= '0;
            bus.store_data  <= '0;
            bus.meta_out    <= '0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
            bus.redirect  <= 1'b0;
        end else if (accept) begin
            bus.store_data  <= bus.r2_data;
            bus.meta_out    <= bus.meta_in;
            bus.out_valid   <= !md_start;
            bus.redirect    <= taken && !md_start;
            bus.redirect_pc <= {sum_ab[XLEN-1:1], 1'b0};
            bus.result      <= taken ? bus.pc + XLEN'(4) : alu_res;
        end else if (md_fin) begin
            bus.out_valid <= 1'b1;
            bus.result    <= md_res;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.redirect  <= 1'b0;
        end
    end

`ifdef EXEC_MULDIV_EN
    // S_IDLE | no mul/div in flight
    // S_BUSY | iterating; cnt counts remaining steps, last step writes the result
    // S_DONE | result beat held until out_ready
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_t;

    md_state_t         state, state_nxt;
    logic [SHW:0]      cnt;
    logic [XLEN-1:0]   w_hi, w_lo, w_b, dvd_raw, step_hi, step_lo, mag_a, mag_b;
    logic [XLEN:0]     add_t, rem_sh, diff;
    logic [2*XLEN-1:0] prod;
    logic [2:0]        md_op;
    logic              sgn_a, sgn_b, neg_a, neg_b, neg_q, neg_r, div0, ovf;

    assign md_start = accept && bus.muldiv_op[3];
    assign sgn_a    = bus.muldiv_op[2:0] inside {3'd1, 3'd2, 3'd4, 3'd6};
    assign sgn_b    = bus.muldiv_op[2:0] inside {3'd1, 3'd4, 3'd6};
    assign neg_a    = sgn_a && op_a[XLEN-1];
    assign neg_b    = sgn_b && op_b[XLEN-1];
    assign mag_a    = neg_a ? -op_a : op_a;
    assign mag_b    = neg_b ? -op_b : op_b;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) state <= S_IDLE;
        else                  state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (md_start) state_nxt = S_BUSY;
            S_BUSY:  if (cnt == (SHW+1)'(1)) state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) state_nxt = md_start ? S_BUSY : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == S_BUSY);
        md_fin = (state == S_BUSY) && (cnt == (SHW+1)'(1));
    end

    // one shift-add or restoring-divide step on magnitudes; signs are restored at the end
    always_comb begin
        add_t  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_b} : '0);
        rem_sh = {w_hi, w_lo[XLEN-1]};
        diff   = rem_sh - {1'b0, w_b};
        if (md_op[2]) begin
            step_hi = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
            step_lo = {w_lo[XLEN-2:0], !diff[XLEN]};
        end else begin
            step_hi = add_t[XLEN:1];
            step_lo = {add_t[0], w_lo[XLEN-1:1]};
        end
    end

    always_comb begin
        prod = {step_hi, step_lo};
        if (neg_q) prod = -prod;
        md_res = '0;
        case (md_op)
            3'd0:       md_res = prod[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       md_res = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5: md_res = div0 ? '1 : ovf ? dvd_raw : (neg_q ? -step_lo : step_lo);
            default:    md_res = div0 ? dvd_raw : ovf ? '0 : (neg_r ? -step_hi : step_hi);
        endcase
    end

    always_ff @(posedge clk) begin
        if (md_start) begin
            w_hi    <= '0;
            w_lo    <= mag_a;
            w_b     <= mag_b;
            md_op   <= bus.muldiv_op[2:0];
            neg_q   <= neg_a ^ neg_b;
            neg_r   <= neg_a;
            div0    <= (op_b == '0);
            ovf     <= sgn_b && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
            dvd_raw <= op_a;
            cnt     <= (SHW+1)'(XLEN);
        end else if (busy) begin
            w_hi <= step_hi;
            w_lo <= step_lo;
            cnt  <= cnt - (SHW+1)'(1);
        end
    end
`else
    logic unused_muldiv;

    assign busy          = 1'b0;
    assign md_start      = 1'b0;
    assign md_fin        = 1'b0;
    assign md_res        = '0;
    assign unused_muldiv = ^bus.muldiv_op;
`endif
endmodule

// File: tb/tb_exec_stage.sv
// Directed and randomized checks of exec_stage against an arithmetic reference model.
module tb_exec_stage;
    localparam int XLEN = 32;

    typedef struct {
        logic [31:0] result;
        logic        redirect;
        logic [31:0] rpc;
        logic [31:0] sdata;
        logic [10:0] meta;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_miss = 0;
    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    exec_if #(.XLEN(XLEN)) bus();
    exec_stage #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model();
        exp_t        m;
        logic [31:0] a, b, r;
        logic        tk;
        a = bus.using_pc ? bus.pc : bus.r1_data;
        b = bus.using_r2 ? bus.r2_data : bus.imm;
        case (bus.alucode)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a << b[4:0];
            4'd3:    r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd4:    r = (a < b) ? 32'd1 : 32'd0;
            4'd5:    r = a ^ b;
            4'd6:    r = a >> b[4:0];
            4'd7:    r = 32'(int'(a) >>> b[4:0]);
            4'd8:    r = a | b;
            4'd9:    r = a & b;
            default: r = b;
        endcase
        case (bus.info_branch)
            3'd1:    tk = bus.r1_data == bus.r2_data;
            3'd2:    tk = bus.r1_data != bus.r2_data;
            3'd3:    tk = int'(bus.r1_data) < int'(bus.r2_data);
            3'd4:    tk = int'(bus.r1_data) >= int'(bus.r2_data);
            3'd5:    tk = bus.r1_data < bus.r2_data;
            3'd6:    tk = bus.r1_data >= bus.r2_data;
            3'd7:    tk = 1'b1;
            default: tk = 1'b0;
        endcase
        m.result   = tk ? bus.pc + 32'd4 : r;
        m.redirect = tk;
        m.rpc      = (a + b) & 32'hFFFF_FFFE;
        m.sdata    = bus.r2_data;
        m.meta     = bus.meta_in;
        return m;
    endfunction

    task automatic check_beat(input string tag, input exp_t x);
        check({tag, "_result"}, bus.result, x.result);
        check({tag, "_redirect"}, bus.redirect, x.redirect);
        if (x.redirect) check({tag, "_rpc"}, bus.redirect_pc, x.rpc);
        check({tag, "_sdata"}, bus.store_data, x.sdata);
        check({tag, "_meta"}, bus.meta_out, x.meta);
    endtask

    task automatic set_instr(input logic [3:0] alu, input logic [31:0] r1, r2, im, p,
                             input logic ur2, upc, input logic [2:0] br, input logic [3:0] md);
        bus.alucode = alu; bus.r1_data = r1; bus.r2_data = r2; bus.imm = im; bus.pc = p;
        bus.using_r2 = ur2; bus.using_pc = upc; bus.info_branch = br; bus.muldiv_op = md;
        bus.meta_in = 11'($urandom);
    endtask

    task automatic rand_instr();
        logic [31:0] r1;
        r1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) - 32'd8 : $urandom;
        set_instr(4'($urandom_range(0, 11)), r1,
                  ($urandom_range(0, 3) == 0) ? r1 : $urandom, $urandom, $urandom & 32'hFFFF_FFFC,
                  1'($urandom), 1'($urandom),
                  ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7)),
`ifdef EXEC_MULDIV_EN
                  {1'b0, 3'($urandom)});
`else
                  4'($urandom));
`endif
    endtask

    task automatic issue_one(input string tag, output exp_t x);
        bus.in_valid = 1'b1;
        #1;
        check({tag, "_in_ready"}, bus.in_ready, 1'b1);
        x = model();
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_out_valid"}, bus.out_valid, 1'b1);
        check_beat(tag, x);
    endtask

`ifdef EXEC_MULDIV_EN
    function automatic logic [31:0] md_model(input logic [2:0] op, input logic [31:0] a, b);
        logic [63:0] pu;
        longint      ps;
        pu = {32'b0, a} * {32'b0, b};
        case (op)
            3'd0: return pu[31:0];
            3'd1: begin ps = longint'(int'(a)) * longint'(int'(b)); return ps[63:32]; end
            3'd2: begin ps = longint'(int'(a)) * longint'({32'b0, b}); return ps[63:32]; end
            3'd3: return pu[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(int'(a) / int'(b));
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(int'(a) % int'(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic md_run(input string tag, input logic [2:0] op, input logic [31:0] a, b);
        int lat;
        set_instr(4'd0, a, b, 32'd0, 32'd0, 1'b1, 1'b0, 3'd0, {1'b1, op});
        bus.in_valid = 1'b1;
        #1;
        check({tag, "_in_ready"}, bus.in_ready, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 33);
        check({tag, "_result"}, bus.result, md_model(op, a, b));
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        set_instr(4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_redirect", bus.redirect, 1'b0);
        check("rst_rpc", bus.redirect_pc, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_sdata", bus.store_data, 32'd0);
        check("rst_meta", bus.meta_out, 11'd0);
        rst = 1'b0;

        // ADD r1=5 + imm=7
        set_instr(4'd0, 32'd5, 32'd0, 32'd7, 32'd0, 1'b0, 1'b0, 3'd0, 4'd0);
        issue_one("add", e);
        check("add_const", bus.result, 32'd12);

        // BLT -1 < 1, target pc+imm
        set_instr(4'd0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 1'b0, 1'b1, 3'd3, 4'd0);
        issue_one("blt", e);
        check("blt_redirect", bus.redirect, 1'b1);
        check("blt_rpc", bus.redirect_pc, 32'h120);
        check("blt_link", bus.result, 32'h104);
        @(negedge clk);
        check("blt_beat_gone", bus.out_valid, 1'b0);
        check("blt_redirect_gone", bus.redirect, 1'b0);

        // backpressure for 3 cycles with a competing instruction waiting
        bus.out_ready = 1'b0;
        set_instr(4'd5, 32'hA5A5_0F0F, 32'h1234_5678, 32'h0, 32'h40, 1'b1, 1'b0, 3'd0, 4'd0);
        issue_one("stall", e);
        rand_instr();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_in_ready", bus.in_ready, 1'b0);
            @(negedge clk);
            check("stall_out_valid", bus.out_valid, 1'b1);
            check_beat("stall_hold", e);
        end
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("stall_single_beat", bus.out_valid, 1'b0);

        // sustained issue, no bubbles
        rand_instr();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("b2b_in_ready", bus.in_ready, 1'b1);
            e = model();
            @(negedge clk);
            check("b2b_out_valid", bus.out_valid, 1'b1);
            check_beat("b2b", e);
            rand_instr();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);

        // flush discards a held jump beat and wins over a simultaneous accept
        bus.out_ready = 1'b0;
        set_instr(4'd0, 32'd0, 32'd0, 32'h11, 32'h200, 1'b0, 1'b1, 3'd7, 4'd0);
        issue_one("jal", e);
        check("jal_rpc", bus.redirect_pc, 32'h210);
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        check("flush_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("flush_out_valid", bus.out_valid, 1'b0);
        check("flush_redirect", bus.redirect, 1'b0);
        @(negedge clk);
        check("flush_no_accept", bus.out_valid, 1'b0);

        // reset with a beat pending
        bus.out_ready = 1'b0;
        set_instr(4'd8, 32'hF0F0_0001, 32'h0F0F_0010, 32'h0, 32'h0, 1'b1, 1'b0, 3'd0, 4'd0);
        issue_one("pre_rst", e);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_in_ready", bus.in_ready, 1'b0);
        check("rst2_out_valid", bus.out_valid, 1'b0);
        check("rst2_result", bus.result, 32'd0);
        check("rst2_sdata", bus.store_data, 32'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;

`ifndef EXEC_MULDIV_EN
        // mul/div encoding is ignored: executes as an ALU add
        set_instr(4'd0, 32'd3, 32'd4, 32'd0, 32'd0, 1'b1, 1'b0, 3'd0, 4'b1100);
        issue_one("md_ignored", e);
        check("md_ignored_const", bus.result, 32'd7);
        @(negedge clk);
`endif

        // randomized traffic with backpressure and occasional flush
        for (int cyc = 0; cyc < 300; cyc++) begin
            logic exp_ov;
            @(negedge clk);
            exp_ov = (q.size() != 0);
            check("rand_out_valid", bus.out_valid, exp_ov);
            if (exp_ov) check_beat("rand", q[0]);
            else        check("rand_idle_redirect", bus.redirect, 1'b0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 19) == 0);
            rand_instr();
            #1;
            check("rand_in_ready", bus.in_ready, !bus.flush && (!exp_ov || bus.out_ready));
            if (bus.flush) q.delete();
            else begin
                if (exp_ov && bus.out_ready) void'(q.pop_front());
                if (bus.in_valid && bus.in_ready) q.push_back(model());
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        q.delete();

`ifdef EXEC_MULDIV_EN
        md_run("div0", 3'd4, 32'd7, 32'd0);
        check("div0_const", bus.result, 32'hFFFF_FFFF);
        md_run("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        check("rem_ovf_const", bus.result, 32'd0);
        md_run("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        md_run("remu0", 3'd7, 32'd99, 32'd0);
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            md_run("md_rand", 3'($urandom_range(0, 7)), a, b);
        end
        @(negedge clk);

        // flush mid-divide: no beat, ready again immediately
        set_instr(4'd0, 32'd100, 32'd7, 32'd0, 32'd0, 1'b1, 1'b0, 3'd0, 4'b1100);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check("mdflush_in_ready_during", bus.in_ready, 1'b0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check("mdflush_in_ready_after", bus.in_ready, 1'b1);
        check("mdflush_out_valid", bus.out_valid, 1'b0);
        begin
            int seen;
            seen = 0;
            repeat (40) begin
                @(negedge clk);
                if (bus.out_valid) seen++;
            end
            check("mdflush_no_beat", seen, 0);
        end

        // reset mid-divide aborts
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mdrst_in_ready", bus.in_ready, 1'b1);
        begin
            int seen;
            seen = 0;
            repeat (40) begin
                @(negedge clk);
                if (bus.out_valid) seen++;
            end
            check("mdrst_no_beat", seen, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
